// File: rtl/ukf_mem_pkg.sv
// Shared constants and types for the UKF memory responder.
// UKF_MEM_REG_OUT_EN adds an output register stage (read latency 2).
package ukf_mem_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 128;
  localparam int LANES_DEF  = DATA_W_DEF / 8;

`ifdef UKF_MEM_REG_OUT_EN
  localparam int READ_LAT = 2;
`else
  localparam int READ_LAT = 1;
`endif

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/ukf_mem_array.sv
// Single-port word store with per-byte write enables and a
// registered read port.
module ukf_mem_array
  import ukf_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/ukf_mem_responder.sv
// Memory-bus responder for the UKF control master: clears all words
// after reset, then serves reads/writes. UKF_MEM_REG_OUT_EN adds a stage.
module ukf_mem_responder
  import ukf_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                clken,
  input  logic                chipselect,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                write,
  input  logic                read,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                err
);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   clr_addr, clr_d;
  logic                acc, wr_en, rd_en;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W/8-1:0] arr_be;
  logic [DATA_W-1:0]   arr_wdata, arr_rdata;
  logic                rd_v1;
  logic                err_q;

  assign acc = (state == READY) & clken & chipselect
             & (read | write);
  assign wr_en = ((state == INIT) & clken) | (acc & write);
  assign rd_en = acc & read & ~write;

  // The clear walk owns the array port while in INIT
  assign arr_addr  = (state == INIT) ? clr_addr : address;
  assign arr_be    = (state == INIT) ? '1 : byteenable;
  assign arr_wdata = (state == INIT) ? '0 : writedata;

  ukf_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clock (clock),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state;
    clr_d   = clr_addr;
    if (clken) begin
      unique case (state)
        INIT: begin
          clr_d = clr_addr + 1'b1;
          if (clr_addr == '1) state_d = READY;
        end
        READY: state_d = READY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= INIT;
      clr_addr <= '0;
      rd_v1    <= 1'b0;
      err_q    <= 1'b0;
    end else if (clken) begin
      state    <= state_d;
      clr_addr <= clr_d;
      rd_v1    <= rd_en;
      if (acc & read & write) err_q <= 1'b1;
    end
  end

`ifdef UKF_MEM_REG_OUT_EN
  logic              rd_v2;
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_v2 <= 1'b0;
      rd_q  <= '0;
    end else if (clken) begin
      rd_v2 <= rd_v1;
      if (rd_v1) rd_q <= arr_rdata;
    end
  end

  assign readdata      = rd_q;
  assign readdatavalid = rd_v2 & clken & ~rst;
`else
  assign readdata      = arr_rdata;
  // Valid is only presented on an enabled cycle; a pending one
  // waits out clken=0 and dies with rst.
  assign readdatavalid = rd_v1 & clken & ~rst;
`endif

  assign waitrequest = (state == INIT);
  assign err         = err_q;

endmodule

// File: doc/ukf_mem_responder.md
UKF_MEM_RESPONDER -- requirements
Module: ukf_mem_responder

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- ADDR_W, 6, word address width; depth = 2**ADDR_W = 64 words.
- DATA_W, 128, word width in bits; byte lanes = DATA_W/8 = 16.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- clken, in, 1, clock enable; when 0, all state holds.
- chipselect, in, 1, selects the block; no access when 0.
- address, in, ADDR_W, word address.
- byteenable, in, DATA_W/8, per-byte write enable.
- write, in, 1, write request.
- read, in, 1, read request.
- writedata, in, DATA_W, write data.
- readdata, out, DATA_W, read data.
- readdatavalid, out, 1, readdata valid this cycle.
- waitrequest, out, 1, request not accepted this cycle.
- err, out, 1, sticky protocol-error flag.

Function
REQ-003 The block SHALL act as the responder for the UKF control master's memory bus and SHALL hold 64 x 128-bit words.
REQ-004 The FSM SHALL have states INIT and READY; rst SHALL force INIT with clr_addr=0.
REQ-005 In INIT, the block SHALL write zero to word clr_addr each cycle with clken=1, increment clr_addr, and go to READY after word 63 (64 cycles); waitrequest SHALL be 1 throughout INIT.
REQ-006 In READY, waitrequest SHALL be 0; an access SHALL be accepted when clken & chipselect & (read | write).
REQ-007 On an accepted write, the block SHALL update only bytes whose byteenable bit is 1; byte k = bits [8k+7:8k].
REQ-008 On an accepted read, readdata SHALL carry mem[address] with readdatavalid=1 exactly 1 cycle after acceptance (baseline latency).
REQ-009 In all other cycles, readdatavalid SHALL be 0 and readdata SHALL hold its last value.
REQ-010 A read and a write to the same address in consecutive cycles SHALL return the newly written data (no stale read).
REQ-011 If read and write are both 1 in one accepted cycle, the block SHALL perform the write, drop the read (no readdatavalid), and set err.
REQ-012 Requests during INIT SHALL be ignored; no write SHALL occur, no readdatavalid SHALL follow, and err SHALL be unchanged.
REQ-013 clken=0 SHALL freeze the FSM, clr_addr, memory and output pipeline; pending readdatavalid SHALL appear on the next clken=1 cycle.
REQ-014 Address arithmetic SHALL be ADDR_W bits with no out-of-range case; clr_addr SHALL wrap from 63 to 0 only on leaving INIT.

Reset
REQ-015 After rst: state=INIT, clr_addr=0, readdata=0, readdatavalid=0, waitrequest=1, err=0; rst SHALL override clken.
REQ-016 rst asserted mid-access or mid-INIT SHALL cancel pending reads (no readdatavalid) and restart the full clear.

Configuration
REQ-017 With macro UKF_MEM_REG_OUT_EN defined, the block SHALL add one output register stage, giving read latency 2; the data/valid pipeline SHALL obey REQ-013 and REQ-016.
REQ-018 Without UKF_MEM_REG_OUT_EN, read latency SHALL be 1; all other behaviour SHALL be identical.

Structure
REQ-019 A shared package ukf_mem_pkg SHALL hold ADDR_W/DATA_W defaults, the lane count, the FSM state enum (INIT, READY) and the read-latency constant.
REQ-020 Storage SHALL sit in one sub-module ukf_mem_array (single port, byte-enable write, synchronous read); the FSM, muxing and pipeline SHALL sit in the top.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, then poll waitrequest: 1 for exactly 64 cycles, then 0; reads of addresses 0 and 63 return 0.
- Write 128'h0123...CDEF to addr 5 with be=16'hFFFF, then read addr 5: readdata equals the written value, readdatavalid at latency 1 (or 2 with UKF_MEM_REG_OUT_EN).
- Write 128'h0 to addr 7, then write all-ones with be=16'h00F0: read gives 128'h0000...FFFFFFFF00000000...; byte 4-7 only.
- Read and write both asserted at addr 9: write lands, no readdatavalid, err=1 and stays 1 until rst.
- Read addr 3 then clken=0 for 3 cycles: readdatavalid appears on the first cycle clken returns to 1.
- rst pulse 1 cycle after a read is accepted: no readdatavalid; waitrequest=1 for 64 cycles; err=0.
